// File: rtl/xrv1_pkg.sv
// Shared types and CSR address map for the xrv1 CSR execution unit.
package xrv1_pkg;

  typedef enum logic [1:0] {
    CSR_OPC_READ  = 2'd0,
    CSR_OPC_WRITE = 2'd1,
    CSR_OPC_SET   = 2'd2,
    CSR_OPC_CLR   = 2'd3
  } xrv_csr_opc_e;

  localparam logic [11:0] CSR_MSCRATCH     = 12'h340;
  localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;
  localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH      = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET     = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH    = 12'hB82;
  localparam logic [11:0] CSR_CYCLE        = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH       = 12'hC80;
  localparam logic [11:0] CSR_INSTRET      = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH     = 12'hC82;

  // Addresses with [11:10] == 2'b11 form the read-only CSR space.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return (addr[11:10] == 2'b11);
  endfunction

endpackage

// File: rtl/xrv1_csr_counter.sv
// Free-running counter with independently writable 32-bit halves.
// A write to either half freezes the counter for that cycle.
module xrv1_csr_counter #(
  parameter int CNT_WIDTH_P = 64,
  parameter int INC_WIDTH_P = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [INC_WIDTH_P-1:0] inc_i,
  input  logic                   wr_lo_i,
  input  logic                   wr_hi_i,
  input  logic [31:0]            wdata_i,
  output logic [CNT_WIDTH_P-1:0] value_o
);

  localparam int HI_W = CNT_WIDTH_P - 32;

  logic [CNT_WIDTH_P-1:0] value_q;
  logic [CNT_WIDTH_P-1:0] value_d;
  logic [CNT_WIDTH_P-1:0] inc_ext;

  // Zero-extend the increment to the counter width.
  always_comb begin
    inc_ext                  = '0;
    inc_ext[INC_WIDTH_P-1:0] = inc_i;
  end

  // Next value: increment, or half replacement with the increment suppressed.
  always_comb begin
    value_d = value_q + inc_ext;
    if (wr_lo_i || wr_hi_i) begin
      value_d = value_q;
      if (wr_lo_i) value_d[31:0] = wdata_i;
      if (wr_hi_i) value_d[CNT_WIDTH_P-1:32] = wdata_i[HI_W-1:0];
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/xrv1_csr_unit.sv
// CSR execution unit: address decode and legality, read-modify-write datapath,
// scratch storage, cycle/instret counters and a single-entry response register.
module xrv1_csr_unit
  import xrv1_pkg::*;
#(
  parameter int ITAG_WIDTH_P  = 2,
  parameter int NUM_SCRATCH_P = 4,
  parameter int CNT_WIDTH_P   = 64,
  parameter int RET_WIDTH_P   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    csr_rdy_o,
  input  logic                    csr_req_vld_i,
  input  logic [1:0]              csr_opc_i,
  input  logic [31:0]             csr_src0_i,
  input  logic [11:0]             csr_addr_i,
  input  logic [ITAG_WIDTH_P-1:0] csr_itag_i,
  output logic                    csr_done_o,
  input  logic                    csr_resp_rdy_i,
  output logic [31:0]             csr_data_o,
  output logic                    csr_ill_o,
  output logic [ITAG_WIDTH_P-1:0] csr_itag_o,
  input  logic [RET_WIDTH_P-1:0]  retire_cnt_i
);

  xrv_csr_opc_e opc;
  logic         accept;
  logic         hit;
  logic         wr_en;
  logic         ill;
  logic         commit;
  logic [31:0]  old_val;
  logic [31:0]  new_val;
  logic [NUM_SCRATCH_P-1:0] scratch_sel;

  logic [31:0] mscratch_q;
  logic [31:0] scratch_q [NUM_SCRATCH_P];

  logic [CNT_WIDTH_P-1:0] mcycle_val;
  logic [CNT_WIDTH_P-1:0] minstret_val;
  logic [63:0]            mcycle64;
  logic [63:0]            minstret64;

  logic                    done_q, done_d;
  logic                    ill_q, ill_d;
  logic [31:0]             data_q, data_d;
  logic [ITAG_WIDTH_P-1:0] itag_q, itag_d;

  assign opc       = xrv_csr_opc_e'(csr_opc_i);
  assign csr_rdy_o = ~done_q | csr_resp_rdy_i;
  assign accept    = csr_req_vld_i & csr_rdy_o;

  // Widen counters to 64 bits so upper bits beyond CNT_WIDTH_P read as zero.
  always_comb begin
    mcycle64                     = '0;
    minstret64                   = '0;
    mcycle64[CNT_WIDTH_P-1:0]    = mcycle_val;
    minstret64[CNT_WIDTH_P-1:0]  = minstret_val;
  end

  // Address decode: hit flag, pre-modification value and scratch select.
  always_comb begin
    hit         = 1'b0;
    old_val     = '0;
    scratch_sel = '0;
    case (csr_addr_i)
      CSR_MSCRATCH:               begin hit = 1'b1; old_val = mscratch_q;         end
      CSR_MCYCLE,   CSR_CYCLE:    begin hit = 1'b1; old_val = mcycle64[31:0];     end
      CSR_MCYCLEH,  CSR_CYCLEH:   begin hit = 1'b1; old_val = mcycle64[63:32];    end
      CSR_MINSTRET, CSR_INSTRET:  begin hit = 1'b1; old_val = minstret64[31:0];   end
      CSR_MINSTRETH, CSR_INSTRETH: begin hit = 1'b1; old_val = minstret64[63:32]; end
      default: ;
    endcase
    for (int i = 0; i < NUM_SCRATCH_P; i++) begin
      if (csr_addr_i == CSR_SCRATCH_BASE + 12'(i)) begin
        hit            = 1'b1;
        old_val        = scratch_q[i];
        scratch_sel[i] = 1'b1;
      end
    end
  end

  // Write enable, legality and read-modify-write result.
  always_comb begin
    wr_en = (opc == CSR_OPC_WRITE) ||
            (((opc == CSR_OPC_SET) || (opc == CSR_OPC_CLR)) && (csr_src0_i != '0));
    ill   = ~hit | (wr_en & csr_is_ro(csr_addr_i));
    case (opc)
      CSR_OPC_WRITE: new_val = csr_src0_i;
      CSR_OPC_SET:   new_val = old_val | csr_src0_i;
      CSR_OPC_CLR:   new_val = old_val & ~csr_src0_i;
      default:       new_val = old_val;
    endcase
  end

  assign commit = accept & wr_en & ~ill;

  // mscratch and scratch file updates on a committed write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mscratch_q <= '0;
      for (int i = 0; i < NUM_SCRATCH_P; i++) scratch_q[i] <= '0;
    end else if (commit) begin
      if (csr_addr_i == CSR_MSCRATCH) mscratch_q <= new_val;
      for (int i = 0; i < NUM_SCRATCH_P; i++) begin
        if (scratch_sel[i]) scratch_q[i] <= new_val;
      end
    end
  end

  xrv1_csr_counter #(.CNT_WIDTH_P(CNT_WIDTH_P), .INC_WIDTH_P(1)) u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .wr_lo_i (commit && (csr_addr_i == CSR_MCYCLE)),
    .wr_hi_i (commit && (csr_addr_i == CSR_MCYCLEH)),
    .wdata_i (new_val),
    .value_o (mcycle_val)
  );

  xrv1_csr_counter #(.CNT_WIDTH_P(CNT_WIDTH_P), .INC_WIDTH_P(RET_WIDTH_P)) u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (retire_cnt_i),
    .wr_lo_i (commit && (csr_addr_i == CSR_MINSTRET)),
    .wr_hi_i (commit && (csr_addr_i == CSR_MINSTRETH)),
    .wdata_i (new_val),
    .value_o (minstret_val)
  );

  // Response next-state: load on accept, clear on pop, otherwise hold.
  always_comb begin
    done_d = done_q;
    ill_d  = ill_q;
    data_d = data_q;
    itag_d = itag_q;
    if (accept) begin
      done_d = 1'b1;
      ill_d  = ill;
      data_d = ill ? 32'h0 : old_val;
      itag_d = csr_itag_i;
    end else if (csr_resp_rdy_i) begin
      done_d = 1'b0;
    end
  end

  // Response register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
      ill_q  <= 1'b0;
      data_q <= '0;
      itag_q <= '0;
    end else begin
      done_q <= done_d;
      ill_q  <= ill_d;
      data_q <= data_d;
      itag_q <= itag_d;
    end
  end

  assign csr_done_o = done_q;
  assign csr_ill_o  = ill_q;
  assign csr_data_o = data_q;
  assign csr_itag_o = itag_q;

endmodule

// File: tb/tb_xrv1_csr_unit.sv
// Scoreboard bench for xrv1_csr_unit with a behavioural CSR model.
module tb_xrv1_csr_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy;
  logic        vld;
  logic [1:0]  opc;
  logic [31:0] src0;
  logic [11:0] addr;
  logic [1:0]  itag;
  logic        done;
  logic        resp_rdy;
  logic [31:0] data;
  logic        ill;
  logic [1:0]  itag_o;
  logic [1:0]  retire;

  int checks = 0;
  int errors = 0;
  bit rand_mode = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        ill;
    logic [1:0]  itag;
  } exp_t;
  exp_t sb[$];

  // Behavioural model state
  logic [31:0]     m_msc;
  logic [31:0]     m_scr [4];
  longint unsigned m_cyc;
  longint unsigned m_ret;
  bit              m_done;

  xrv1_csr_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .csr_rdy_o      (rdy),
    .csr_req_vld_i  (vld),
    .csr_opc_i      (opc),
    .csr_src0_i     (src0),
    .csr_addr_i     (addr),
    .csr_itag_i     (itag),
    .csr_done_o     (done),
    .csr_resp_rdy_i (resp_rdy),
    .csr_data_o     (data),
    .csr_ill_o      (ill),
    .csr_itag_o     (itag_o),
    .retire_cnt_i   (retire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mread(input logic [11:0] a, output logic [31:0] v);
    v = 32'h0;
    if (a == 12'h340)                        begin v = m_msc; return 1'b1; end
    if (a >= 12'h7C0 && a <= 12'h7C3)        begin v = m_scr[a - 12'h7C0]; return 1'b1; end
    if (a == 12'hB00 || a == 12'hC00)        begin v = m_cyc[31:0];  return 1'b1; end
    if (a == 12'hB80 || a == 12'hC80)        begin v = m_cyc[63:32]; return 1'b1; end
    if (a == 12'hB02 || a == 12'hC02)        begin v = m_ret[31:0];  return 1'b1; end
    if (a == 12'hB82 || a == 12'hC82)        begin v = m_ret[63:32]; return 1'b1; end
    return 1'b0;
  endfunction

  // Reference model: steps once per clock edge from the sampled inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_msc = 0;
      foreach (m_scr[i]) m_scr[i] = 0;
      m_cyc = 0;
      m_ret = 0;
      m_done = 0;
      sb.delete();
    end else begin
      bit acc, ok, we, il;
      bit cw_lo, cw_hi, rw_lo, rw_hi;
      logic [31:0] old, nv;
      cw_lo = 0; cw_hi = 0; rw_lo = 0; rw_hi = 0; nv = 0;
      acc = vld && (!m_done || resp_rdy);
      if (acc) begin
        ok = mread(addr, old);
        we = (opc == 2'd1) || (opc >= 2'd2 && src0 != 0);
        il = !ok || (we && addr[11:10] == 2'b11);
        sb.push_back('{il ? 32'h0 : old, il, itag});
        if (!il && we) begin
          nv = (opc == 2'd1) ? src0 : (opc == 2'd2) ? (old | src0) : (old & ~src0);
          if (addr == 12'h340) m_msc = nv;
          else if (addr >= 12'h7C0 && addr <= 12'h7C3) m_scr[addr - 12'h7C0] = nv;
          else if (addr == 12'hB00) cw_lo = 1;
          else if (addr == 12'hB80) cw_hi = 1;
          else if (addr == 12'hB02) rw_lo = 1;
          else if (addr == 12'hB82) rw_hi = 1;
        end
      end
      if (cw_lo || cw_hi) begin
        if (cw_lo) m_cyc[31:0]  = nv;
        if (cw_hi) m_cyc[63:32] = nv;
      end else m_cyc = m_cyc + 1;
      if (rw_lo || rw_hi) begin
        if (rw_lo) m_ret[31:0]  = nv;
        if (rw_hi) m_ret[63:32] = nv;
      end else m_ret = m_ret + retire;
      if (acc) m_done = 1;
      else if (resp_rdy) m_done = 0;
    end
  end

  // Monitor: compares the presented response against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rdy", 64'(rdy), 64'(!m_done || resp_rdy));
      chk("done", 64'(done), 64'(m_done));
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty actual=response required=none at %0t", $time);
        end else begin
          chk("data", 64'(data), 64'(sb[0].data));
          chk("ill", 64'(ill), 64'(sb[0].ill));
          chk("itag", 64'(itag_o), 64'(sb[0].itag));
          if (resp_rdy) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      resp_rdy = ($urandom_range(0, 3) != 0);
      retire   = 2'($urandom_range(0, 3));
    end
    #1;
  endtask

  task automatic send(input logic [1:0] o, input logic [11:0] a, input logic [31:0] s,
                      input logic [1:0] t);
    bit r, acc;
    acc = 0;
    vld = 1; opc = o; addr = a; src0 = s; itag = t;
    for (int n = 0; n < 60; n++) begin
      r = rdy;
      tick();
      if (r) begin acc = 1; break; end
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=0 required=1 at %0t", $time);
    end
    vld = 0;
  endtask

  task automatic idle(input int n);
    vld = 0;
    repeat (n) tick();
  endtask

  logic [11:0] alist [16] = '{12'h340, 12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3, 12'h7C4,
                              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                              12'hC02, 12'hC82, 12'h123, 12'h341};

  initial begin
    vld = 0; opc = 0; addr = 0; src0 = 0; itag = 0; resp_rdy = 1; retire = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ill", 64'(ill), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_itag", 64'(itag_o), 64'd0);
    chk("rst_rdy", 64'(rdy), 64'd1);
    rst = 0;
    idle(1);

    // Write then read mscratch
    send(2'd1, 12'h340, 32'hDEADBEEF, 2'd1);
    send(2'd0, 12'h340, 32'h0, 2'd2);
    // SET / CLR read-modify-write
    send(2'd1, 12'h340, 32'h0000F0F0, 2'd3);
    send(2'd2, 12'h340, 32'h0000000F, 2'd0);
    send(2'd3, 12'h340, 32'h000000F0, 2'd1);
    send(2'd0, 12'h340, 32'h0, 2'd2);
    // Read-only and unmapped accesses
    send(2'd1, 12'hC00, 32'h5, 2'd3);
    send(2'd2, 12'hC00, 32'h0, 2'd0);
    send(2'd0, 12'h123, 32'h0, 2'd1);
    send(2'd0, 12'hB00, 32'h0, 2'd2);
    // Counter carry across the halves and retire accumulation
    send(2'd1, 12'hB80, 32'h0, 2'd0);
    send(2'd1, 12'hB00, 32'hFFFFFFFF, 2'd1);
    idle(1);
    send(2'd0, 12'hB00, 32'h0, 2'd2);
    send(2'd0, 12'hB80, 32'h0, 2'd3);
    send(2'd1, 12'hB02, 32'h0, 2'd0);
    retire = 2'd3;
    idle(4);
    retire = 2'd0;
    send(2'd0, 12'hB02, 32'h0, 2'd1);
    send(2'd0, 12'hC02, 32'h0, 2'd2);
    // Back-pressure: hold the response, then pop and accept together
    resp_rdy = 0;
    send(2'd0, 12'h340, 32'h0, 2'd3);
    idle(5);
    resp_rdy = 1;
    send(2'd1, 12'h7C1, 32'h12345678, 2'd0);
    send(2'd0, 12'h7C1, 32'h0, 2'd1);
    // Asynchronous reset while a response is pending
    send(2'd1, 12'h7C2, 32'hA5A5A5A5, 2'd2);
    resp_rdy = 0;
    send(2'd0, 12'h7C2, 32'h0, 2'd3);
    #2;
    rst = 1;
    #1;
    chk("async_rst_done", 64'(done), 64'd0);
    tick();
    rst = 0;
    resp_rdy = 1;
    send(2'd0, 12'h340, 32'h0, 2'd0);
    send(2'd0, 12'h7C2, 32'h0, 2'd1);
    send(2'd0, 12'hB02, 32'h0, 2'd2);
    send(2'd0, 12'hB80, 32'h0, 2'd3);
    // Randomized traffic
    rand_mode = 1;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] s;
      s = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      send(2'($urandom_range(0, 3)), alist[$urandom_range(0, 15)], s, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rand_mode = 0;
    resp_rdy = 1;
    retire = 0;
    idle(3);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
